// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and types for the interrupt request-capture stage.
package irq_pending_ctrl_pkg;

    localparam int N_LINES = 4;
    localparam int IDX_W   = 2;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } line_state_t;

endpackage

// File: rtl/irq_line_cell.sv
// One request line: event detect, sticky pending/overflow state and ack handling.
//   state | meaning
//   IDLE  | no request outstanding on this line
//   PEND  | request captured, waiting for the consumer's ack
module irq_line_cell
    import irq_pending_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic evt,
    input  logic mode,
    input  logic ack_hit,
    input  logic clr_all,
    output logic pending,
    output logic ovf
);

    line_state_t state;
    line_state_t state_next;
    logic        ovf_next;
    logic        prev;
    logic        evt_det;
    logic        ack_wins;

    assign evt_det = (mode == MODE_EDGE) ? (evt & ~prev) : evt;

    // A fresh edge beats a coincident ack; a held level does not, so the ack
    // drops the line for one edge before the level re-captures it.
    assign ack_wins = ack_hit & (state == PEND) & ~(evt_det & (mode == MODE_EDGE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ovf   <= 1'b0;
            prev  <= 1'b0;
        end else begin
            state <= state_next;
            ovf   <= ovf_next;
            prev  <= evt;
        end
    end

    always_comb begin
        state_next = state;
        ovf_next   = ovf;
        if (clr_all) begin
            state_next = IDLE;
            ovf_next   = 1'b0;
        end else if (ack_wins) begin
            state_next = IDLE;
        end else if (evt_det) begin
            if ((state == PEND) && !ack_hit) begin
                ovf_next = 1'b1;
            end
            state_next = PEND;
        end
    end

    always_comb begin
        pending = (state == PEND);
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky request capture with per-line mask, feeding the downstream priority encoder.
module irq_pending_ctrl #(
    parameter int N_LINES = irq_pending_ctrl_pkg::N_LINES,
    parameter int IDX_W   = irq_pending_ctrl_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] evt_in,
    input  logic [N_LINES-1:0] edge_mode,
    input  logic [N_LINES-1:0] en_mask,
    input  logic               ack_valid,
    input  logic [IDX_W-1:0]   ack_id,
    input  logic               clr_all,
    output logic [N_LINES-1:0] req_out,
    output logic               req_any,
    output logic [N_LINES-1:0] pending,
    output logic [N_LINES-1:0] ovf,
    output logic               ack_err
);

    logic [N_LINES-1:0] ack_hot;
    logic               ack_bad;

    // Out-of-range ids decode to no line, so they fall out as "not pending".
    always_comb begin
        ack_hot = '0;
        for (int i = 0; i < N_LINES; i++) begin
            ack_hot[i] = ack_valid && (ack_id == IDX_W'(i));
        end
    end

    assign ack_bad = ack_valid & ~clr_all & ~(|(ack_hot & pending));

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err <= 1'b0;
        end else begin
            ack_err <= ack_bad;
        end
    end

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        irq_line_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .evt     (evt_in[i]),
            .mode    (edge_mode[i]),
            .ack_hit (ack_hot[i]),
            .clr_all (clr_all),
            .pending (pending[i]),
            .ovf     (ovf[i])
        );
    end

    assign req_out = pending & en_mask;
    assign req_any = |req_out;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed vector bench for irq_pending_ctrl: table of per-cycle stimulus plus corner sequences.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] evt_in, edge_mode, en_mask;
    logic       ack_valid;
    logic [1:0] ack_id;
    logic       clr_all;
    logic [3:0] req_out, pending, ovf;
    logic       req_any, ack_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .evt_in    (evt_in),
        .edge_mode (edge_mode),
        .en_mask   (en_mask),
        .ack_valid (ack_valid),
        .ack_id    (ack_id),
        .clr_all   (clr_all),
        .req_out   (req_out),
        .req_any   (req_any),
        .pending   (pending),
        .ovf       (ovf),
        .ack_err   (ack_err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] evt;
        logic [3:0] edm;
        logic [3:0] msk;
        logic       av;
        logic [1:0] aid;
        logic       clr;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic       aerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] e, logic [3:0] m, logic [3:0] k,
                                logic a, logic [1:0] id, logic c,
                                logic [3:0] p, logic [3:0] o, logic ae);
        vec_t v;
        v.rst = r; v.evt = e; v.edm = m; v.msk = k; v.av = a; v.aid = id; v.clr = c;
        v.pend = p; v.ovf = o; v.aerr = ae;
        return v;
    endfunction

    task automatic check(string name, int step, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%b want=%b", name, step, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; evt_in = v.evt; edge_mode = v.edm; en_mask = v.msk;
        ack_valid = v.av; ack_id = v.aid; clr_all = v.clr;
    endtask

    task automatic check_all(string tag, int step, logic [3:0] p, logic [3:0] o,
                             logic [3:0] k, logic ae);
        logic [3:0] exp_req;
        exp_req = p & k;
        check({tag, "_pending"}, step, pending, p);
        check({tag, "_ovf"},     step, ovf, o);
        check({tag, "_req_out"}, step, req_out, exp_req);
        check({tag, "_req_any"}, step, {3'b000, req_any}, {3'b000, |exp_req});
        check({tag, "_ack_err"}, step, {3'b000, ack_err}, {3'b000, ae});
    endtask

    initial begin
        //            rst evt      edm      msk      av  aid clr  pend     ovf      aerr
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0)); // 0
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 4'b0000, 0)); // 4 edge
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b1111, 1, 1, 0, 4'b0000, 4'b0000, 0)); // 7 ack
        vecs.push_back(mk(0, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 4'b0000, 0)); // 10
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 4'b0100, 0)); // ovf
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b1111, 4'b1111, 1, 2, 0, 4'b0100, 4'b0100, 0)); // 14 edge beats ack
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 2, 0, 4'b0000, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b1111, 4'b0111, 0, 0, 0, 4'b1000, 4'b0100, 0)); // 16 masked
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b0111, 0, 0, 0, 4'b1000, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b1000, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 1, 4'b0000, 4'b0000, 0)); // 19 clr
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b1111, 0, 0, 0, 4'b0001, 4'b0000, 0)); // 20 level
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b1111, 1, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b1111, 0, 0, 0, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 0, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 1, 3, 0, 4'b0001, 4'b0000, 1)); // 24 bad ack
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 0, 0, 0, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b1111, 1, 0, 1, 4'b0000, 4'b0000, 0)); // 26 clr+ack+evt
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1011, 4'b1111, 4'b1111, 0, 0, 0, 4'b1011, 4'b0000, 0));
        vecs.push_back(mk(1, 4'b1011, 4'b1111, 4'b1111, 1, 3, 0, 4'b0000, 4'b0000, 0)); // 29 rst
        vecs.push_back(mk(0, 4'b1011, 4'b1111, 4'b1111, 0, 0, 0, 4'b1011, 4'b0000, 0)); // high after rst = edge
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 4'b1011, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 2, 0, 4'b1011, 4'b0000, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b1111, 4'b1111, 1, 1, 0, 4'b1001, 4'b0000, 0));

        // Reset then ten idle cycles with all inputs low.
        rst = 1'b1; evt_in = '0; edge_mode = '0; en_mask = '0;
        ack_valid = 1'b0; ack_id = '0; clr_all = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_all("idle", c, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].pend, vecs[i].ovf, vecs[i].msk, vecs[i].aerr);
        end

        // Masked capture, then unmask: request must appear without a clock edge.
        @(negedge clk);
        rst = 1'b0; evt_in = 4'b0000; edge_mode = 4'b1111; en_mask = 4'b0111;
        ack_valid = 1'b0; ack_id = '0; clr_all = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_all = 1'b0; evt_in = 4'b1000;
        @(posedge clk);
        #1;
        check_all("mask_hidden", 0, 4'b1000, 4'b0000, 4'b0111, 1'b0);
        @(negedge clk);
        evt_in = 4'b0000; en_mask = 4'b1111;
        #1;
        check("unmask_req_out", 0, req_out, 4'b1000);
        check("unmask_req_any", 0, {3'b000, req_any}, 4'b0001);

        // Ack on a pending line with no event, then the same ack again errors.
        @(negedge clk);
        ack_valid = 1'b1; ack_id = 2'd3;
        @(posedge clk);
        #1;
        check_all("ack_ok", 0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        check_all("ack_again", 0, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        @(negedge clk);
        ack_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ack_err_pulse", 0, {3'b000, ack_err}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
